// File: rtl/flags_int_unit_if.sv
// -----------------------------------------------------------------------------
// flags_int_unit_if
//
// Purpose:
//   Groups the strobe, flag and interrupt signals exchanged between the RAT
//   control unit (master) and the flags/interrupt front end (slave).
//
// Signal summary:
//   C_IN, Z_IN      ALU carry / zero results
//   FLG_C_SET       force C to 1
//   FLG_C_CLR       force C to 0
//   FLG_C_LD        load C from the selected source
//   FLG_Z_LD        load Z from the selected source
//   FLG_LD_SEL      0 = ALU source, 1 = shadow flags (RETIE restore)
//   FLG_SHAD_LD     copy live C/Z into the shadows (interrupt entry / ack)
//   I_SET, I_CLR    interrupt-mask set / clear
//   INT_IN          asynchronous external interrupt request
//   C_FLAG, Z_FLAG  live flags back to the control unit
//   I_FLAG          interrupt-enable mask
//   INT_CU          interrupt request to the control unit
// -----------------------------------------------------------------------------
interface flags_int_unit_if;
  logic C_IN;
  logic Z_IN;
  logic FLG_C_SET;
  logic FLG_C_CLR;
  logic FLG_C_LD;
  logic FLG_Z_LD;
  logic FLG_LD_SEL;
  logic FLG_SHAD_LD;
  logic I_SET;
  logic I_CLR;
  logic INT_IN;

  logic C_FLAG;
  logic Z_FLAG;
  logic I_FLAG;
  logic INT_CU;

  // Control-unit side: drives the strobes and observes the flags.
  modport master (
    output C_IN, Z_IN,
    output FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD,
    output FLG_LD_SEL, FLG_SHAD_LD,
    output I_SET, I_CLR,
    output INT_IN,
    input  C_FLAG, Z_FLAG, I_FLAG, INT_CU
  );

  // Flags/interrupt unit side.
  modport slave (
    input  C_IN, Z_IN,
    input  FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD,
    input  FLG_LD_SEL, FLG_SHAD_LD,
    input  I_SET, I_CLR,
    input  INT_IN,
    output C_FLAG, Z_FLAG, I_FLAG, INT_CU
  );
endinterface

// File: rtl/flags_int_unit.sv
// -----------------------------------------------------------------------------
// flags_int_unit
//
// Purpose:
//   Flags-and-interrupt front end for the RAT control unit. Holds the live
//   C/Z flags, their shadow copies used across an interrupt, and the
//   interrupt-enable mask. Synchronises the external interrupt line, latches
//   a pending request, and presents INT_CU = pending & I to the control unit.
//
// Parameters:
//   SYNC_STAGES  flops in the INT_IN synchroniser (legal range 2..4)
//   INT_EDGE     1 = rising-edge latch, 0 = level-sensitive pending
//
// Ports:
//   CLK   system clock, all state changes on its rising edge
//   RST   synchronous active-high reset, overrides every other input
//   bus   flags_int_unit_if.slave (strobes in, C/Z/I flags and INT_CU out)
//
// Notes:
//   - Outputs come straight from flops (INT_CU is an AND of two flops), so
//     there is no combinational path from INT_IN or any strobe to an output.
//   - INT_IN pulses shorter than one CLK period may be missed.
// -----------------------------------------------------------------------------
module flags_int_unit #(
  parameter int SYNC_STAGES = 2,
  parameter bit INT_EDGE    = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  flags_int_unit_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic c_reg,       c_next;
  logic z_reg,       z_next;
  logic shad_c_reg,  shad_c_next;
  logic shad_z_reg,  shad_z_next;
  logic i_reg,       i_next;
  logic int_s_d_reg;
  logic pending_reg, pending_next;

  logic [SYNC_STAGES-1:0] sync_reg;

  logic int_s;
  logic int_rise;
  logic int_set;
  logic int_ack;
  logic int_cu;
  logic ld_c_src;
  logic ld_z_src;

  // ---------------------------------------------------------------------------
  // INT_IN synchroniser: stage 0 samples the asynchronous line, each later
  // stage samples its predecessor. The last stage is the usable level.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge CLK) begin
          if (RST) begin
            sync_reg[gi] <= 1'b0;
          end else begin
            sync_reg[gi] <= bus.INT_IN;
          end
        end
      end else begin : g_rest
        always_ff @(posedge CLK) begin
          if (RST) begin
            sync_reg[gi] <= 1'b0;
          end else begin
            sync_reg[gi] <= sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign int_s    = sync_reg[SYNC_STAGES-1];
  assign int_rise = int_s & ~int_s_d_reg;

  // Set condition for the pending latch depends on the trigger mode.
  generate
    if (INT_EDGE) begin : g_edge
      assign int_set = int_rise;
    end else begin : g_level
      assign int_set = int_s;
    end
  endgenerate

  // The request is only visible when unmasked, so an acknowledge can only
  // happen for a request the control unit actually saw.
  assign int_cu  = pending_reg & i_reg;
  assign int_ack = bus.FLG_SHAD_LD & int_cu;

  // ---------------------------------------------------------------------------
  // Load-source selection shared by C and Z.
  // ---------------------------------------------------------------------------
  assign ld_c_src = bus.FLG_LD_SEL ? shad_c_reg : bus.C_IN;
  assign ld_z_src = bus.FLG_LD_SEL ? shad_z_reg : bus.Z_IN;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    c_next = c_reg;
    if (bus.FLG_C_CLR) begin
      c_next = 1'b0;
    end else if (bus.FLG_C_SET) begin
      c_next = 1'b1;
    end else if (bus.FLG_C_LD) begin
      c_next = ld_c_src;
    end
  end

  always_comb begin
    z_next = z_reg;
    if (bus.FLG_Z_LD) begin
      z_next = ld_z_src;
    end
  end

  // Shadows capture the pre-edge live flags. Because the restore path reads
  // the old shadow value and the capture path reads the old live value, a
  // simultaneous FLG_SHAD_LD + restore swaps the two registers cleanly.
  always_comb begin
    shad_c_next = shad_c_reg;
    shad_z_next = shad_z_reg;
    if (bus.FLG_SHAD_LD) begin
      shad_c_next = c_reg;
      shad_z_next = z_reg;
    end
  end

  always_comb begin
    i_next = i_reg;
    if (bus.I_CLR) begin
      i_next = 1'b0;
    end else if (bus.I_SET) begin
      i_next = 1'b1;
    end
  end

  // A new request arriving in the acknowledge cycle must not be lost, so the
  // set term dominates the clear term.
  always_comb begin
    pending_next = pending_reg;
    if (int_set) begin
      pending_next = 1'b1;
    end else if (int_ack) begin
      pending_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      c_reg       <= 1'b0;
      z_reg       <= 1'b0;
      shad_c_reg  <= 1'b0;
      shad_z_reg  <= 1'b0;
      i_reg       <= 1'b0;
      int_s_d_reg <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      c_reg       <= c_next;
      z_reg       <= z_next;
      shad_c_reg  <= shad_c_next;
      shad_z_reg  <= shad_z_next;
      i_reg       <= i_next;
      int_s_d_reg <= int_s;
      pending_reg <= pending_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.C_FLAG = c_reg;
  assign bus.Z_FLAG = z_reg;
  assign bus.I_FLAG = i_reg;
  assign bus.INT_CU = int_cu;

endmodule

// File: tb/tb_flags_int_unit.sv
// -----------------------------------------------------------------------------
// tb_flags_int_unit
//
// Self-checking bench for flags_int_unit (SYNC_STAGES=2, INT_EDGE=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the following rising edge. Each step pushes its expected output
// record to a scoreboard queue before the edge and pops it after.
// -----------------------------------------------------------------------------
module tb_flags_int_unit;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  flags_int_unit_if bus();

  flags_int_unit #(
    .SYNC_STAGES (2),
    .INT_EDGE    (1'b1)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    string name;
    logic  c;
    logic  z;
    logic  i;
    logic  int_cu;
  } exp_t;

  // Input order: c_clr c_set c_ld z_ld ld_sel shad_ld c_in z_in i_set i_clr
  // Expected order: c z i
  typedef struct {
    logic [9:0] in;
    logic [2:0] exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  int   errors = 0;
  int   checks = 0;
  logic exp_c, exp_z, exp_i;

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic clear_strobes();
    bus.C_IN        = 1'b0;
    bus.Z_IN        = 1'b0;
    bus.FLG_C_SET   = 1'b0;
    bus.FLG_C_CLR   = 1'b0;
    bus.FLG_C_LD    = 1'b0;
    bus.FLG_Z_LD    = 1'b0;
    bus.FLG_LD_SEL  = 1'b0;
    bus.FLG_SHAD_LD = 1'b0;
    bus.I_SET       = 1'b0;
    bus.I_CLR       = 1'b0;
  endtask

  // One clock edge: queue the expectation, advance, pop and compare.
  task automatic step(input string name, input logic exp_int);
    exp_t e;
    e.name   = name;
    e.c      = exp_c;
    e.z      = exp_z;
    e.i      = exp_i;
    e.int_cu = exp_int;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check_bit({e.name, ".C_FLAG"}, bus.C_FLAG, e.c);
    check_bit({e.name, ".Z_FLAG"}, bus.Z_FLAG, e.z);
    check_bit({e.name, ".I_FLAG"}, bus.I_FLAG, e.i);
    check_bit({e.name, ".INT_CU"}, bus.INT_CU, e.int_cu);
    $display("%-12s C=%b Z=%b I=%b INT_CU=%b (exp %b%b%b%b)", e.name,
             bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_CU,
             e.c, e.z, e.i, e.int_cu);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table, applied back-to-back from C=0 Z=0 shadows=0 I=0.
    vecs[0]  = '{10'b0011001110, 3'b111}; // C_LD,Z_LD from ALU=1, I_SET
    vecs[1]  = '{10'b1110001011, 3'b010}; // CLR>SET>LD, SET+CLR -> I=0
    vecs[2]  = '{10'b0110000010, 3'b111}; // SET>LD (C_IN=0), I_SET
    vecs[3]  = '{10'b0010000000, 3'b011}; // LD only, C_IN=0
    vecs[4]  = '{10'b0100000001, 3'b110}; // SET, I_CLR
    vecs[5]  = '{10'b0001000000, 3'b100}; // Z_LD Z_IN=0 -> C=1 Z=0
    vecs[6]  = '{10'b1001010100, 3'b010}; // save (1,0), CLR, Z_LD Z_IN=1
    vecs[7]  = '{10'b0011100100, 3'b100}; // restore from shadow (1,0)
    vecs[8]  = '{10'b1001000100, 3'b010}; // live -> (0,1)
    vecs[9]  = '{10'b0011110000, 3'b100}; // save+restore swap
    vecs[10] = '{10'b0011101000, 3'b010}; // restore shadow (0,1), ALU ignored
    vecs[11] = '{10'b0000001000, 3'b010}; // no strobe: hold
    vecs[12] = '{10'b0011001000, 3'b100}; // load from ALU (1,0)
    vecs[13] = '{10'b0100000010, 3'b101}; // SET, I_SET

    clear_strobes();
    bus.INT_IN = 1'b0;
    RST = 1'b1;
    exp_c = 1'b0; exp_z = 1'b0; exp_i = 1'b0;
    @(posedge CLK); #1;
    step("init_rst", 1'b0);
    RST = 1'b0;

    // ---- Reset: make every state bit 1 first, then reset with inputs high.
    bus.FLG_C_SET = 1'b1; bus.FLG_Z_LD = 1'b1; bus.Z_IN = 1'b1; bus.I_SET = 1'b1;
    exp_c = 1'b1; exp_z = 1'b1; exp_i = 1'b1;
    step("rst_prep", 1'b0);
    clear_strobes();
    bus.FLG_SHAD_LD = 1'b1;
    step("rst_save", 1'b0);
    {bus.C_IN, bus.Z_IN, bus.FLG_C_SET, bus.FLG_C_CLR, bus.FLG_C_LD, bus.FLG_Z_LD,
     bus.FLG_LD_SEL, bus.FLG_SHAD_LD, bus.I_SET, bus.I_CLR, bus.INT_IN} = '1;
    RST = 1'b1;
    exp_c = 1'b0; exp_z = 1'b0; exp_i = 1'b0;
    step("rst_all", 1'b0);
    RST = 1'b0;
    clear_strobes();
    bus.INT_IN = 1'b0;
    bus.FLG_LD_SEL = 1'b1; bus.FLG_C_LD = 1'b1; bus.FLG_Z_LD = 1'b1;
    bus.C_IN = 1'b1; bus.Z_IN = 1'b1;
    step("rst_shadow", 1'b0);
    clear_strobes();

    // ---- Table-driven flag / mask vectors.
    for (int k = 0; k < 14; k++) begin
      {bus.FLG_C_CLR, bus.FLG_C_SET, bus.FLG_C_LD, bus.FLG_Z_LD, bus.FLG_LD_SEL,
       bus.FLG_SHAD_LD, bus.C_IN, bus.Z_IN, bus.I_SET, bus.I_CLR} = vecs[k].in;
      {exp_c, exp_z, exp_i} = vecs[k].exp;
      step($sformatf("vec%0d", k), 1'b0);
    end
    clear_strobes();

    // ---- Interrupt latency and acknowledge (I=1 already).
    bus.I_SET = 1'b1;
    step("lat_e0", 1'b0);
    clear_strobes();
    bus.INT_IN = 1'b1;
    step("lat_e1", 1'b0);
    step("lat_e2", 1'b0);
    step("lat_e3", 1'b1);
    step("lat_e4", 1'b1);
    bus.FLG_SHAD_LD = 1'b1;
    step("lat_e5_ack", 1'b0);
    clear_strobes();
    for (int k = 6; k <= 10; k++) step($sformatf("lat_e%0d", k), 1'b0);
    bus.INT_IN = 1'b0;
    for (int k = 0; k < 4; k++) step("idle", 1'b0);

    // ---- Masked request held until I_SET.
    bus.I_CLR = 1'b1;
    exp_i = 1'b0;
    step("msk_e0", 1'b0);
    clear_strobes();
    bus.INT_IN = 1'b1;
    step("msk_e1", 1'b0);
    step("msk_e2", 1'b0);
    step("msk_e3", 1'b0);
    bus.INT_IN = 1'b0;
    for (int k = 4; k <= 9; k++) step($sformatf("msk_e%0d", k), 1'b0);
    bus.I_SET = 1'b1;
    exp_i = 1'b1;
    step("msk_e10", 1'b1);
    bus.I_CLR = 1'b1;
    exp_i = 1'b0;
    step("msk_setclr", 1'b0);
    bus.I_CLR = 1'b0;
    exp_i = 1'b1;
    step("msk_reset", 1'b1);
    clear_strobes();
    bus.FLG_SHAD_LD = 1'b1;
    step("msk_ack", 1'b0);
    clear_strobes();
    step("idle", 1'b0);

    // ---- New rise landing in the acknowledge cycle keeps pending set.
    step("race_e0", 1'b0);
    bus.INT_IN = 1'b1;
    step("race_e1", 1'b0);
    bus.INT_IN = 1'b0;
    step("race_e2", 1'b0);
    step("race_e3", 1'b1);
    bus.INT_IN = 1'b1;
    step("race_e4", 1'b1);
    step("race_e5", 1'b1);
    bus.FLG_SHAD_LD = 1'b1;
    step("race_e6_ack", 1'b1);
    step("race_e7_ack", 1'b0);
    clear_strobes();
    step("race_e8", 1'b0);

    // ---- Reset while a request is being presented.
    bus.INT_IN = 1'b0;
    for (int k = 0; k < 3; k++) step("idle", 1'b0);
    bus.INT_IN = 1'b1;
    step("mid_e1", 1'b0);
    step("mid_e2", 1'b0);
    step("mid_e3", 1'b1);
    RST = 1'b1;
    exp_c = 1'b0; exp_z = 1'b0; exp_i = 1'b0;
    step("mid_rst", 1'b0);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) step($sformatf("mid_hold%0d", k), 1'b0);
    bus.FLG_LD_SEL = 1'b1; bus.FLG_C_LD = 1'b1; bus.FLG_Z_LD = 1'b1;
    step("mid_shadow", 1'b0);
    clear_strobes();
    bus.INT_IN = 1'b0;

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flags_int_unit.md
Name: flags_int_unit

Overview:
- Flags-and-interrupt front end for the RAT control unit.
- Holds the architectural C and Z flags, their shadow copies, and the interrupt-enable (I) mask.
- Synchronises the external interrupt line and produces the INT_CU request.
- Consumes the control unit's FLG_*/I_* strobes and feeds C_FLAG, Z_FLAG and INT_CU back to it.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the INT_IN synchroniser (legal range 2-4)
INT_EDGE, 1, 1 = rising-edge-triggered interrupt latch; 0 = level-sensitive (pending follows the synchronised level)

Ports:
CLK  in  1  system clock, all state updates on the rising edge
RST  in  1  synchronous, active-high reset
C_IN  in  1  carry result from the ALU
Z_IN  in  1  zero result from the ALU
FLG_C_SET  in  1  force C to 1
FLG_C_CLR  in  1  force C to 0
FLG_C_LD  in  1  load C from the selected source
FLG_Z_LD  in  1  load Z from the selected source
FLG_LD_SEL  in  1  0 = load source is the ALU (C_IN/Z_IN); 1 = load source is the shadow flags (RETIE restore)
FLG_SHAD_LD  in  1  copy live C/Z into the shadow registers (interrupt entry)
I_SET  in  1  set the interrupt mask (SEI)
I_CLR  in  1  clear the interrupt mask (CLI / interrupt entry)
INT_IN  in  1  asynchronous external interrupt request
C_FLAG  out  1  live carry flag
Z_FLAG  out  1  live zero flag
I_FLAG  out  1  interrupt-enable mask
INT_CU  out  1  interrupt request to the control unit

Behaviour:
- Single clock domain (CLK). Reset is synchronous and active-high on RST.
- RST=1 at a rising edge clears the following to 0: C, Z, shadow C, shadow Z, I, the synchroniser chain, the edge-history flop and pending. All outputs read 0 from the next cycle.
- RST overrides every other input in the same cycle, including mid-interrupt.
- C update priority per edge: FLG_C_CLR > FLG_C_SET > FLG_C_LD > hold.
  - Load source is C_IN when FLG_LD_SEL=0, shadow C when FLG_LD_SEL=1.
- Z update: FLG_Z_LD loads Z_IN or shadow Z (same FLG_LD_SEL rule); otherwise hold.
- Shadow capture: FLG_SHAD_LD=1 stores the pre-edge C_FLAG/Z_FLAG values.
  - A simultaneous live-flag update still takes effect; the shadow receives the old value.
  - FLG_SHAD_LD together with FLG_LD_SEL=1 restore is legal: both registers swap values in one edge.
- I mask: I_CLR > I_SET > hold.
- Synchroniser: INT_IN passes through SYNC_STAGES flops to give int_s.
- INT_EDGE=1:
  - Edge detect: rise = int_s & ~int_s_d, where int_s_d is int_s delayed one cycle.
  - A rise sets pending at the next edge.
  - A held-high INT_IN produces exactly one request.
- INT_EDGE=0: pending is set whenever int_s=1.
- Pending clears on the edge where FLG_SHAD_LD=1 and INT_CU=1 (interrupt acknowledge).
  - If a new rise occurs in the acknowledge cycle, set wins and pending stays 1.
- INT_CU = pending & I_FLAG (combinational from registers, glitch-free).
  - A request arriving while I=0 is held and asserts INT_CU on the cycle after I_SET.
- Latency, SYNC_STAGES=2, INT_EDGE=1: INT_IN rising before edge n gives INT_CU=1 after edge n+2 (three edges, assuming I=1).
- Pulses on INT_IN shorter than one CLK period may be missed. This is a documented limitation, not an error.
- No state machine beyond pending; no combinational path from INT_IN to any output.

Test Plan:
1. Reset: drive all inputs 1, then RST=1 for one edge, others 0 → C_FLAG=Z_FLAG=I_FLAG=INT_CU=0; shadows read 0 via a later FLG_LD_SEL=1 restore.
2. C priority: FLG_C_CLR=FLG_C_SET=FLG_C_LD=1 with C_IN=1 → C=0. Then SET+LD with C_IN=0 → C=1. Then LD only with C_IN=0 → C=0.
3. Shadow save/restore: C=1, Z=0, FLG_SHAD_LD=1 with FLG_C_CLR=1 and FLG_Z_LD=1 (Z_IN=1) → live C=0, Z=1. Next cycle FLG_LD_SEL=1, FLG_C_LD=FLG_Z_LD=1 → C=1, Z=0.
4. Interrupt latency: I=1, INT_IN rises just after edge 0 and is held high 10 cycles → INT_CU=1 after edge 3. Acknowledge (FLG_SHAD_LD=1) at edge 5 → INT_CU=0 after edge 5, with no second request.
5. Masked request: I=0, INT_IN pulses high for 3 cycles → INT_CU stays 0. I_SET at edge 10 → INT_CU=1 after edge 10. I_SET+I_CLR together → I=0.
6. Reset mid-interrupt: pending=1, I=1, assert RST for one edge → INT_CU=0, and no re-assertion while INT_IN stays high.
